// File: rtl/sigma_timer.sv
// rtl/sigma_timer.sv - memory-mapped 32-bit timer/compare peripheral with level IRQ
//
// Purpose:
//   Timer/compare block on the core's external data bus. Decodes a 16-byte
//   register window at BASE_ADDR, counts prescaled clock ticks, and raises a
//   level interrupt on compare match. One-shot and periodic (auto-reload) modes.
//
// Register map (offset = addr[3:2]):
//   0 CTRL   [0] EN, [1] RELOAD, [2] IRQ_EN, other bits read 0
//   1 LIMIT  compare value (RW)
//   2 COUNT  current count (RW)
//   3 STATUS [0] MATCH, write-1-to-clear
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   bus_req_i     bus request
//   bus_we_i      1 = write, 0 = read
//   bus_addr_bi   byte address
//   bus_be_bi     byte enables for writes
//   bus_wdata_bi  write data
//   bus_ack_o     request accepted (combinational, only inside the window)
//   bus_resp_o    read data valid, one cycle after an accepted read
//   bus_rdata_bo  read data, zero whenever bus_resp_o is low
//   irq_o         timer interrupt, level (MATCH & IRQ_EN)

module sigma_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0010,
    parameter int unsigned PRESC_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    localparam int unsigned   PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LIMIT  = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Architectural state
    logic          ctrl_en;
    logic          ctrl_reload;
    logic          ctrl_irq_en;
    logic [31:0]   limit_q;
    logic [31:0]   count_q;
    logic          match_q;
    logic [PW-1:0] presc_q;

    // Next-state values
    logic          ctrl_en_nx;
    logic          ctrl_reload_nx;
    logic          ctrl_irq_en_nx;
    logic [31:0]   limit_nx;
    logic [31:0]   count_nx;
    logic          match_nx;
    logic [PW-1:0] presc_nx;

    logic          hit;
    logic          wr_acc;
    logic          rd_acc;
    logic [1:0]    reg_sel;
    logic          tick;
    logic          cmp_hit;
    logic [31:0]   rd_mux;

    // Word-aligned access only; the low address bits carry no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus_addr_bi[1:0];

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Bus decode
    assign hit       = (bus_addr_bi[31:4] == BASE_ADDR[31:4]);
    assign bus_ack_o = bus_req_i & hit;
    assign wr_acc    = bus_ack_o & bus_we_i;
    assign rd_acc    = bus_ack_o & ~bus_we_i;
    assign reg_sel   = bus_addr_bi[3:2];

    // Tick and compare always use the pre-write register values.
    assign tick    = ctrl_en & (presc_q == PRESC_LAST);
    assign cmp_hit = (count_q == limit_q);

    always_comb begin
        rd_mux = 32'd0;
        case (reg_sel)
            REG_CTRL:   rd_mux = {29'd0, ctrl_irq_en, ctrl_reload, ctrl_en};
            REG_LIMIT:  rd_mux = limit_q;
            REG_COUNT:  rd_mux = count_q;
            REG_STATUS: rd_mux = {31'd0, match_q};
            default:    rd_mux = 32'd0;
        endcase
    end

    // Prescaler: free-runs only while enabled; disabling restarts it at 0.
    always_comb begin
        presc_nx = presc_q;
        if (!ctrl_en) begin
            presc_nx = '0;
        end else if (tick) begin
            presc_nx = '0;
        end else begin
            presc_nx = presc_q + 1'b1;
        end
    end

    // Register update. The tick result is computed first and the bus write is
    // layered on top, so written CTRL/COUNT bytes win over the tick. MATCH is
    // the opposite: the W1C clear is applied first and a same-cycle match wins.
    always_comb begin
        ctrl_en_nx     = ctrl_en;
        ctrl_reload_nx = ctrl_reload;
        ctrl_irq_en_nx = ctrl_irq_en;
        limit_nx       = limit_q;
        count_nx       = count_q;
        match_nx       = match_q;

        if (tick) begin
            if (cmp_hit) begin
                if (ctrl_reload) begin
                    count_nx = 32'd0;
                end else begin
                    ctrl_en_nx = 1'b0;
                end
            end else begin
                count_nx = count_q + 32'd1;
            end
        end

        if (wr_acc) begin
            case (reg_sel)
                REG_CTRL: begin
                    if (bus_be_bi[0]) begin
                        ctrl_en_nx     = bus_wdata_bi[0];
                        ctrl_reload_nx = bus_wdata_bi[1];
                        ctrl_irq_en_nx = bus_wdata_bi[2];
                    end
                end
                REG_LIMIT:  limit_nx = merge_bytes(limit_q, bus_wdata_bi, bus_be_bi);
                REG_COUNT:  count_nx = merge_bytes(count_nx, bus_wdata_bi, bus_be_bi);
                REG_STATUS: begin
                    if (bus_be_bi[0] && bus_wdata_bi[0]) begin
                        match_nx = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (tick && cmp_hit) begin
            match_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en      <= 1'b0;
            ctrl_reload  <= 1'b0;
            ctrl_irq_en  <= 1'b0;
            limit_q      <= 32'd0;
            count_q      <= 32'd0;
            match_q      <= 1'b0;
            presc_q      <= '0;
            bus_resp_o   <= 1'b0;
            bus_rdata_bo <= 32'd0;
        end else begin
            ctrl_en      <= ctrl_en_nx;
            ctrl_reload  <= ctrl_reload_nx;
            ctrl_irq_en  <= ctrl_irq_en_nx;
            limit_q      <= limit_nx;
            count_q      <= count_nx;
            match_q      <= match_nx;
            presc_q      <= presc_nx;
            // Read data is captured at the accept edge and held only for the
            // single response cycle.
            bus_resp_o   <= rd_acc;
            bus_rdata_bo <= rd_acc ? rd_mux : 32'd0;
        end
    end

    // Both operands are flops, so there is no path from the bus to the IRQ.
    assign irq_o = match_q & ctrl_irq_en;

endmodule

// File: tb/tb_sigma_timer.sv
// tb/tb_sigma_timer.sv - scoreboard testbench for sigma_timer

module tb_sigma_timer;

    localparam logic [31:0] BASE1 = 32'h8000_0010;
    localparam logic [31:0] BASE4 = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        ack1, resp1, irq1;
    logic [31:0] rdata1;
    logic        ack4, resp4, irq4;
    logic [31:0] rdata4;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    logic [31:0] q1[$];
    logic [31:0] q4[$];

    always #5 clk = ~clk;

    sigma_timer #(.BASE_ADDR(BASE1), .PRESC_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack1), .bus_resp_o(resp1), .bus_rdata_bo(rdata1), .irq_o(irq1)
    );

    sigma_timer #(.BASE_ADDR(BASE4), .PRESC_DIV(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(ack4), .bus_resp_o(resp4), .bus_rdata_bo(rdata4), .irq_o(irq4)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response, checks idle data.
    always @(negedge clk) begin
        if (resp1) begin
            if (q1.size() == 0) check_value("resp1_unexpected", 32'(resp1), 32'd0);
            else                check_value("rdata1", rdata1, q1.pop_front());
        end else begin
            check_value("rdata1_idle", rdata1, 32'd0);
        end
        if (resp4) begin
            if (q4.size() == 0) check_value("resp4_unexpected", 32'(resp4), 32'd0);
            else                check_value("rdata4", rdata4, q4.pop_front());
        end else begin
            check_value("rdata4_idle", rdata4, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_wr(input bit d4, input logic [31:0] off, input logic [3:0] bev,
                          input logic [31:0] data);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = (d4 ? BASE4 : BASE1) + off; be = bev; wdata = data;
        #1 check_value("wr_ack", 32'(d4 ? ack4 : ack1), 32'd1);
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic bus_rd(input bit d4, input logic [31:0] off, input logic [31:0] exp);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = (d4 ? BASE4 : BASE1) + off;
        #1 check_value("rd_ack", 32'(d4 ? ack4 : ack1), 32'd1);
        if (d4) q4.push_back(exp);
        else    q1.push_back(exp);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    // Cycles until irq1 rises, 0 if it never does within the budget.
    task automatic wait_irq(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (irq1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'h0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_irq1", 32'(irq1), 32'd0);
        check_value("reset_resp1", 32'(resp1), 32'd0);
        check_value("reset_irq4", 32'(irq4), 32'd0);
        rst = 1'b0;
        bus_rd(0, 32'h0, 32'd0);
        bus_rd(0, 32'h4, 32'd0);
        bus_rd(0, 32'h8, 32'd0);
        bus_rd(0, 32'hC, 32'd0);
        bus_rd(1, 32'h8, 32'd0);

        // Periodic mode
        bus_wr(0, 32'h4, 4'hF, 32'd5);
        bus_wr(0, 32'h0, 4'hF, 32'h7);
        wait_irq(n);
        check_value("periodic_first", 32'(n), 32'd6);
        bus_wr(0, 32'hC, 4'hF, 32'd1);
        check_value("irq_drop_after_w1c", 32'(irq1), 32'd0);
        wait_irq(n);
        check_value("periodic_second", 32'(n), 32'd5);
        bus_wr(0, 32'h0, 4'hF, 32'h0);
        bus_rd(0, 32'h8, 32'd1);
        bus_rd(0, 32'hC, 32'd1);
        bus_rd(0, 32'h0, 32'd0);
        bus_wr(0, 32'hC, 4'hF, 32'd1);
        check_value("irq_clear_idle", 32'(irq1), 32'd0);

        // One-shot mode
        bus_wr(0, 32'h8, 4'hF, 32'd0);
        bus_wr(0, 32'h4, 4'hF, 32'd3);
        bus_wr(0, 32'h0, 4'hF, 32'h5);
        wait_irq(n);
        check_value("oneshot_match", 32'(n), 32'd4);
        bus_rd(0, 32'h0, 32'h4);
        bus_rd(0, 32'h8, 32'd3);
        bus_wr(0, 32'hC, 4'hF, 32'd1);
        repeat (10) @(posedge clk);
        #1 check_value("oneshot_no_rematch", 32'(irq1), 32'd0);
        bus_rd(0, 32'hC, 32'd0);
        bus_rd(0, 32'h8, 32'd3);

        // Byte enables, decode window, back-to-back reads
        bus_wr(0, 32'h4, 4'hF, 32'd0);
        bus_wr(0, 32'h4, 4'b0010, 32'hAABB_CCDD);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = BASE1 + 32'h20;
        #1 check_value("out_of_window_ack1", 32'(ack1), 32'd0);
        check_value("out_of_window_ack4", 32'(ack4), 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        bus_rd(0, 32'h4, 32'h0000_CC00);
        bus_wr(0, 32'h8, 4'h0, 32'h1234);
        bus_rd(0, 32'h8, 32'd3);
        bus_rd(0, 32'h4, 32'h0000_CC00);
        bus_rd(0, 32'h8, 32'd3);

        // Wrap through 0xFFFFFFFF
        bus_wr(0, 32'h4, 4'hF, 32'd1);
        bus_wr(0, 32'h8, 4'hF, 32'hFFFF_FFFE);
        bus_wr(0, 32'h0, 4'hF, 32'h5);
        wait_irq(n);
        check_value("wrap_match", 32'(n), 32'd4);
        bus_rd(0, 32'h8, 32'd1);
        bus_wr(0, 32'hC, 4'hF, 32'd1);

        // COUNT write on a tick cycle wins
        bus_wr(0, 32'h4, 4'hF, 32'd100);
        bus_wr(0, 32'h8, 4'hF, 32'd0);
        bus_wr(0, 32'h0, 4'hF, 32'h1);
        bus_wr(0, 32'h8, 4'hF, 32'h50);
        bus_wr(0, 32'h0, 4'hF, 32'h0);
        bus_rd(0, 32'h8, 32'h51);

        // LIMIT=0 with reload: match every tick, W1C loses to a same-cycle match
        bus_wr(0, 32'h4, 4'hF, 32'd0);
        bus_wr(0, 32'h8, 4'hF, 32'd0);
        bus_wr(0, 32'h0, 4'hF, 32'h3);
        bus_wr(0, 32'hC, 4'hF, 32'd1);
        check_value("irq_gated_by_irq_en", 32'(irq1), 32'd0);
        bus_rd(0, 32'hC, 32'd1);
        bus_wr(0, 32'h0, 4'hF, 32'h0);
        bus_wr(0, 32'hC, 4'hF, 32'd1);
        bus_rd(0, 32'hC, 32'd0);

        // Prescaler divide-by-4
        bus_wr(1, 32'h4, 4'hF, 32'h0000_FFFF);
        bus_wr(1, 32'h0, 4'hF, 32'h1);
        repeat (10) @(posedge clk);
        bus_wr(1, 32'h0, 4'hF, 32'h0);
        bus_rd(1, 32'h8, 32'd2);
        bus_wr(1, 32'h0, 4'hF, 32'h1);
        repeat (2) @(posedge clk);
        bus_wr(1, 32'h0, 4'hF, 32'h0);
        bus_rd(1, 32'h8, 32'd2);

        // Reset with a read being accepted cancels the response
        bus_wr(0, 32'h4, 4'hF, 32'h1234_5678);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = BASE1 + 32'h4; rst = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check_value("reset_cancels_resp", 32'(resp1), 32'd0);
        rst = 1'b0;
        bus_rd(0, 32'h4, 32'd0);

        repeat (3) @(negedge clk);
        check_value("scoreboard1_drained", 32'(q1.size()), 32'd0);
        check_value("scoreboard4_drained", 32'(q4.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
